// File: rtl/count_sched_if.sv
// rtl/count_sched_if.sv - requester/scheduler handshake bundle for count_sched
interface count_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] load_val;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic [WIDTH-1:0]       count;
  logic [N_REQ-1:0]       done;

  // requester side drives requests and load values, observes the scheduler
  modport master (
    output req, load_val,
    input  grant, busy, count, done
  );

  // scheduler side
  modport slave (
    input  req, load_val,
    output grant, busy, count, done
  );
endinterface

// File: rtl/count_sched.sv
// rtl/count_sched.sv - round-robin scheduler sharing one down-counter among requesters
module count_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int PTR_W = 2
) (
  input logic          clk,
  input logic          rst,
  count_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t             state, state_n;
  logic [WIDTH-1:0]   count_q, count_n;
  logic [PTR_W-1:0]   w, w_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [N_REQ-1:0]   grant_q, grant_n;
  logic [N_REQ-1:0]   done_q, done_n;
  logic               busy_q, busy_n;

  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   w_next;
  int                 idx;

  // all state and outputs are registered; reset drops everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= '0;
      w       <= '0;
      ptr     <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      w       <= w_n;
      ptr     <= ptr_n;
      grant_q <= grant_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
    end
  end

  // round-robin pick: first set request at or above ptr, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  // pointer lands just past the job that finished or aborted
  always_comb begin
    w_next = (w == PTR_W'(N_REQ - 1)) ? '0 : w + PTR_W'(1);
  end

  // next-state and registered-output logic
  always_comb begin
    state_n = state;
    count_n = count_q;
    w_n     = w;
    ptr_n   = ptr;
    grant_n = grant_q;
    done_n  = '0;
    busy_n  = busy_q;
    case (state)
      IDLE: begin
        grant_n = '0;
        busy_n  = 1'b0;
        if (found) begin
          state_n = RUN;
          w_n     = pick;
          grant_n = ONE << pick;
          count_n = bus.load_val[pick*WIDTH +: WIDTH];
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (!bus.req[w]) begin
          // abort wins over counting and completion
          state_n = IDLE;
          grant_n = '0;
          count_n = '0;
          busy_n  = 1'b0;
          ptr_n   = w_next;
        end else if (count_q != '0) begin
          count_n = count_q - WIDTH'(1);
        end else begin
          state_n = DONE;
          grant_n = '0;
          busy_n  = 1'b0;
          done_n  = ONE << w;
          ptr_n   = w_next;
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_count_sched.sv
// tb/tb_count_sched.sv - directed scoreboard bench for count_sched
module tb_count_sched;
  localparam int N_REQ = 4;
  localparam int WIDTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  count_sched_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  count_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] count;
    logic [3:0] done;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] g, input logic b,
                      input logic [3:0] c, input logic [3:0] d);
    exp_t e;
    e.tag = tag; e.grant = g; e.busy = b; e.count = c; e.done = d;
    sb.push_back(e);
  endtask

  // one full job: L+1 RUN cycles counting down, one DONE cycle, one IDLE cycle
  task automatic exp_job(input string tag, input int idx, input int l);
    logic [3:0] oh;
    oh = 4'(1 << idx);
    for (int j = 0; j <= l; j++) push(tag, oh, 1'b1, 4'(l - j), 4'b0000);
    push(tag, 4'b0000, 1'b0, 4'b0000, oh);
    push(tag, 4'b0000, 1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic check_now(input string tag, input logic [3:0] g, input logic b,
                           input logic [3:0] c, input logic [3:0] d);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
  endtask

  // step one clock per queued expectation and compare just after the edge
  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_now(e.tag, e.grant, e.busy, e.count, e.done);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [15:0] lv);
    @(negedge clk);
    bus.req      = r;
    bus.load_val = lv;
  endtask

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset", 4'b0000, 1'b0, 4'd0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // single request, load 3 on requester 1
    drive(4'b0010, 16'h0030);
    exp_job("single", 1, 3);
    drain();
    drive(4'b0000, 16'h0000);

    // requester 0 with load 5, reset while counting
    drive(4'b0001, 16'h0005);
    push("pre_rst", 4'b0001, 1'b1, 4'd5, 4'b0000);
    push("pre_rst", 4'b0001, 1'b1, 4'd4, 4'b0000);
    drain();
    #2 rst = 1'b1;
    #1;
    check_now("rst_mid", 4'b0000, 1'b0, 4'd0, 4'b0000);
    @(negedge clk);
    bus.req      = 4'b1111;
    bus.load_val = 16'h0000;
    @(negedge clk);
    rst = 1'b0;

    // all requesting with zero loads: order 0,1,2,3,0 from reset pointer
    exp_job("rr0", 0, 0);
    exp_job("rr1", 1, 0);
    exp_job("rr2", 2, 0);
    exp_job("rr3", 3, 0);
    exp_job("rr0b", 0, 0);
    drain();
    drive(4'b0000, 16'h0000);

    // maximum load on requester 1: 16 RUN cycles, no wrap
    drive(4'b0010, 16'h00F0);
    exp_job("max", 1, 15);
    drain();
    drive(4'b0000, 16'h0000);

    // abort requester 2 after two RUN cycles
    drive(4'b0100, 16'h0500);
    push("abort_run", 4'b0100, 1'b1, 4'd5, 4'b0000);
    push("abort_run", 4'b0100, 1'b1, 4'd4, 4'b0000);
    drain();
    drive(4'b0000, 16'h1500);
    push("abort", 4'b0000, 1'b0, 4'd0, 4'b0000);
    drain();
    drive(4'b1100, 16'h1500);
    exp_job("after_abort", 3, 1);
    drain();
    drive(4'b0000, 16'h0000);

    // reset with count at 2, then a pending request wins immediately
    drive(4'b0010, 16'h0040);
    push("pre_rst2", 4'b0010, 1'b1, 4'd4, 4'b0000);
    push("pre_rst2", 4'b0010, 1'b1, 4'd3, 4'b0000);
    push("pre_rst2", 4'b0010, 1'b1, 4'd2, 4'b0000);
    drain();
    #2 rst = 1'b1;
    #1;
    check_now("rst_mid2", 4'b0000, 1'b0, 4'd0, 4'b0000);
    @(posedge clk);
    #1;
    check_now("rst_hold", 4'b0000, 1'b0, 4'd0, 4'b0000);
    @(negedge clk);
    bus.req      = 4'b0100;
    bus.load_val = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    exp_job("post_rst", 2, 0);
    drain();
    drive(4'b0000, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/count_sched.md
# count_sched

Round-robin scheduler that shares one down-counter timing resource among up to N_REQ requesters. Each requester raises a request with its own load value. The scheduler grants the counter to one requester at a time, counts the load value down to zero, and pulses a per-requester done. It sits between requesting control blocks and the counter datapath, and owns all sequencing of that counter.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 4: counter width in bits.
- PTR_W, default 2: round-robin pointer width, equal to clog2(N_REQ).
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level, held until done or abort.
- load_val  input  N_REQ*WIDTH  packed load values; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ  one-hot grant, or zero when nobody is granted.
- busy  output  1  high while in RUN.
- count  output  WIDTH  current counter value.
- done  output  N_REQ  one-cycle one-hot completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- State registers: state, count, winner index w, and pointer ptr.
- IDLE
  - grant=0, busy=0, done=0.
  - If req!=0, the winner w is the first set req bit scanning upward from ptr, wrapping modulo N_REQ.
  - Next edge: state=RUN, grant[w]=1, count=load_val[w], busy=1.
  - load_val is sampled only at this edge. Later changes to load_val are ignored.
- RUN
  - Abort has priority. If req[w]=0 while in RUN, the next edge goes to IDLE with grant=0, count=0, no done pulse, and ptr=(w+1) mod N_REQ.
  - If count!=0, count decrements by 1 each edge.
  - If count==0, the next edge goes to DONE with grant=0, busy=0, done[w]=1, and ptr=(w+1) mod N_REQ.
- DONE
  - done[w]=1 for exactly this one cycle.
  - Next edge returns unconditionally to IDLE; done clears.
- Arithmetic
  - count is unsigned WIDTH bits.
  - It never decrements below 0; there is no wrap.
  - load_val=0 is legal and gives one RUN cycle.
- Fairness
  - The requester just served or aborted has the lowest priority in the next arbitration.
  - No requester waits more than N_REQ-1 services.
- Requests from non-granted requesters may rise or fall at any time. They are evaluated only in IDLE.
- Reset values (asynchronous, immediate): state=IDLE, grant=0, busy=0, count=0, done=0, ptr=0, w=0.
  - Reset mid-RUN or mid-DONE drops grant and done at once.
  - No done pulse is produced for the interrupted job.

## Timing
- Take req sampled in IDLE at edge k, with load value L.
  - grant and busy are valid after edge k.
  - count shows L, L-1, …, 0 after edges k through k+L.
  - done is high for the cycle after edge k+L+1; grant falls at the same edge.
  - IDLE follows edge k+L+2.
  - The next grant appears after edge k+L+3 at the earliest.
- Back-to-back service period is L+3 cycles.
- Abort seen at edge m: grant and count are 0 after edge m. A new grant is possible after edge m+1.
- Outputs are registered; there is no combinational path from req or load_val to any output.

## Test plan
- Reset: assert rst mid-cycle with req=4'b0001 -> grant, busy, count, and done are 0 immediately. After release, ptr=0.
- Single request: req=4'b0010, load_val[1]=3 -> grant=4'b0010 for 4 cycles, count 3,2,1,0, then done=4'b0010 for 1 cycle.
- Round-robin: req=4'b1111 held, all loads 0 -> grant order 0,1,2,3,0; each grant lasts 1 cycle; service period is 3 cycles.
- Zero/max load: load 0 -> one RUN cycle. Load 15 (WIDTH=4) -> 16 RUN cycles; count never wraps past 0.
- Abort: grant to requester 2 with load 5, drop req[2] after 2 RUN cycles -> grant=0 and count=0 at the next edge, no done pulse, next winner is requester 3 when req=4'b1100.
- Reset mid-RUN with count=2 -> no done pulse. After release, a pending req=4'b0100 wins starting from ptr=0 and is granted 1 cycle after the IDLE edge.
